ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//   Instruction fetch front end: the initiator side of the combinational instruction
//   memory read port (byte-address pc in, 32-bit little-endian instr out, same cycle).
//   Owns the fetch PC, drives it to the memory and captures {pc, instr} pairs into a
//   small FIFO. Presents them to decode over a valid/ready handshake.
//   Accepts redirects (branch/jump) that flush the FIFO and restart fetch.
// PARAMETERS
//   RESET_PC   32'h0000_0000  fetch PC loaded on reset
//   DEPTH      2              FIFO entries (power of two, >=2)
//   MEM_BYTES  4096           instruction memory size in bytes (power of two); PC wraps modulo this
// PORTS
//   clk           in   1   clock, all state on rising edge
//   rst_n         in   1   asynchronous active-low reset
//   imem_pc       out  32  fetch address to instruction memory (= fetch_pc register)
//   imem_instr    in   32  instruction word at imem_pc, same cycle
//   redirect_valid in  1   flush and restart fetch at redirect_pc
//   redirect_pc   in   32  new fetch address
//   out_valid     out  1   FIFO head valid
//   out_ready     in   1   decode accepts head
//   out_pc        out  32  PC of head entry
//   out_instr     out  32  instruction of head entry
//   out_misalign  out  1   head entry is a misaligned-target marker (only with FETCH_MISALIGN_TRAP_EN)
// BEHAVIOUR
//   Reset (async, immediate): fetch_pc=RESET_PC, count=0, out_valid=0, out_pc=0,
//     out_instr=0, out_misalign=0; imem_pc=RESET_PC.
//   pop  = out_valid & out_ready. push = (count<DEPTH | pop) & ~halt & ~redirect_valid.
//   On push: entry {imem_pc, imem_instr} written at tail; fetch_pc <= (fetch_pc+4) mod MEM_BYTES.
//   out_* driven from registered head entry; out_valid = (count!=0). Fetch-to-out latency 1 cycle.
//   Simultaneous push+pop with count==DEPTH: allowed, count unchanged; order preserved.
//   Full (count==DEPTH, no pop): no push, fetch_pc and imem_pc hold.
//   Empty: out_valid=0; out_pc/out_instr hold last values (don't-care).
//   Redirect (highest priority): at edge count<=0, fetch_pc<=redirect_pc (masked, see
//     CONFIGURATION), halt<=0; a pop in the same cycle is a completed transfer; no push that
//     cycle. out_valid=0 the cycle after redirect; first redirected entry valid the cycle after that.
//   Back-to-back redirects: last one wins; each restarts the sequence above.
//   Wrap: fetch_pc at MEM_BYTES-4 advances to 0. Upper bits of redirect_pc above
//     log2(MEM_BYTES) are discarded.
//   out_* stable while out_valid & ~out_ready (no change without pop or redirect).
//   Reset mid-operation: all entries discarded, state as reset, no spurious out_valid.
// CONFIGURATION
//   FETCH_MISALIGN_TRAP_EN defined:
//     - Redirect with redirect_pc[1:0]!=0 loads fetch_pc. Next cycle pushes one entry
//       {pc=redirect_pc, instr=32'h0, misalign=1} and sets halt (no further pushes).
//     - Stays halted until the next redirect or reset. Aligned entries carry misalign=0.
//   Not defined: redirect_pc[1:0] forced to 2'b00; out_misalign port absent; halt never set.
// TESTING
//   1 Reset release, out_ready=1, memory word=addr -> out_pc 0x0,0x4,0x8... one per cycle,
//     out_instr==out_pc, first out_valid 1 cycle after first edge.
//   2 out_ready=0 from reset -> count reaches 2 (pc 0x0,0x4 queued), imem_pc holds 0x8;
//     raise out_ready -> 0x0,0x4,0x8 in order, no gaps or duplicates.
//   3 FIFO full, pulse redirect_valid with redirect_pc=0x40 -> next cycle out_valid=0;
//     following cycle out_pc=0x40, then 0x44. Entries 0x0/0x4 never appear.
//   4 MEM_BYTES=4096, redirect to 0xFF8, out_ready=1 -> out_pc 0xFF8,0xFFC,0x000,0x004.
//   5 (macro on) redirect to 0x42 -> one entry out_pc=0x42, out_misalign=1, out_instr=0,
//     then out_valid=0 indefinitely; redirect to 0x80 -> fetch resumes at 0x80, misalign=0.
//     (macro off) redirect to 0x42 -> out_pc=0x40.
//   6 Assert rst_n=0 mid-stream with count=2 -> out_valid=0 immediately (async);
//     on release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_if.sv
// Bundle between the fetch unit, the instruction memory read port and decode.
// Optional build macro: FETCH_MISALIGN_TRAP_EN adds the out_misalign signal.
//
// Handshake: an entry moves from fetch to decode on a rising clk edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, out_pc/out_instr (and out_misalign) hold their values.
// out_valid never depends combinationally on out_ready. The memory side has
// no handshake: imem_instr is the word at imem_pc in the same cycle.
interface ifetch_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  // Fetch unit side
  modport master (
    input  imem_instr, redirect_valid, redirect_pc, out_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output out_misalign,
`endif
    output imem_pc, out_valid, out_pc, out_instr
  );

  // Memory / decode / branch-unit side
  modport slave (
    output imem_instr, redirect_valid, redirect_pc, out_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  out_misalign,
`endif
    input  imem_pc, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads the combinational
// instruction memory and queues {pc, instr} pairs for decode in a small FIFO.
// Redirects flush the FIFO and restart fetch at the new (wrapped) address.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target
// produces one marker entry and then halts fetch until the next redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_BYTES = 4096
) (
  input  logic      clk,
  input  logic      rst_n,
  ifetch_if.master  fetch_bus
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C   = (PW + 1)'(DEPTH);
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          push, pop;
  logic [31:0]   pc_plus4;
  logic [31:0]   redirect_target;
  logic [31:0]   push_instr;
  logic          halt;
  logic          fetch_misaligned;

  assign pc_plus4 = fetch_pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q;
  logic mis_mem_q [DEPTH];

  // Misaligned targets are kept so they can be reported as a marker entry.
  assign redirect_target  = fetch_bus.redirect_pc & ADDR_MASK;
  assign fetch_misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign push_instr       = fetch_misaligned ? 32'h0 : fetch_bus.imem_instr;
  assign halt             = halt_q;
  assign fetch_bus.out_misalign = mis_mem_q[head_q];

  // Halt after the marker entry is queued; only a redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (fetch_bus.redirect_valid) begin
      halt_q <= 1'b0;
    end else if (push && fetch_misaligned) begin
      halt_q <= 1'b1;
    end
  end

  // Misalign flag storage, written alongside the pc/instr entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mis_mem_q[i] <= 1'b0;
    end else if (push) begin
      mis_mem_q[tail_q] <= fetch_misaligned;
    end
  end
`else
  // Without the trap, targets are word-aligned by dropping the low bits.
  assign redirect_target  = fetch_bus.redirect_pc & ADDR_MASK & ~32'd3;
  assign fetch_misaligned = 1'b0;
  assign push_instr       = fetch_bus.imem_instr;
  assign halt             = 1'b0;
`endif

  assign fetch_bus.imem_pc   = fetch_pc_q;
  assign fetch_bus.out_valid = (count_q != '0);
  assign fetch_bus.out_pc    = pc_mem_q[head_q];
  assign fetch_bus.out_instr = instr_mem_q[head_q];

  // Next-state: redirect beats everything; otherwise push/pop the FIFO.
  always_comb begin
    pop        = (count_q != '0) && fetch_bus.out_ready;
    push       = ((count_q < DEPTH_C) || pop) && !halt && !fetch_bus.redirect_valid;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;
    if (fetch_bus.redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_target;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        if (!fetch_misaligned) fetch_pc_d = pc_plus4 & ADDR_MASK;
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    end
  end

  // Control registers: fetch PC, occupancy and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= push_instr;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed redirect/backpressure/reset sequences,
// a queue-based reference of the fetch stream compared every cycle, and
// hand-computed literal checks at key points.
`timescale 1ns/1ps
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_BYTES = 4096;
  localparam logic [31:0] KEY       = 32'hC0DE_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_if fetch_bus();

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_bus(fetch_bus)
  );

  // Instruction memory: word derived from its address, distinct from the pc.
  assign fetch_bus.imem_instr = fetch_bus.imem_pc ^ KEY;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The fetch stream is a sequence of addresses; the FIFO is a queue.
  entry_t      m_q[$];
  logic [31:0] m_pc   = RESET_PC;
  bit          m_halt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    entry_t e;
    bit     m_pop, m_push;
    if (!rst_n) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else begin
      m_pop  = (m_q.size() != 0) && fetch_bus.out_ready;
      m_push = ((m_q.size() < DEPTH) || m_pop) && !m_halt && !fetch_bus.redirect_valid;
      if (m_pop) void'(m_q.pop_front());
      if (fetch_bus.redirect_valid) begin
        m_q.delete();
        m_pc = fetch_bus.redirect_pc % MEM_BYTES;
`ifndef FETCH_MISALIGN_TRAP_EN
        m_pc = m_pc - (m_pc % 4);
`endif
        m_halt = 1'b0;
      end else if (m_push) begin
        e.pc = m_pc;
        if ((m_pc % 4) != 0) begin
          e.instr = 32'h0;
          e.mis   = 1'b1;
          m_halt  = 1'b1;
        end else begin
          e.instr = m_pc ^ KEY;
          e.mis   = 1'b0;
          m_pc    = (m_pc + 4) % MEM_BYTES;
        end
        m_q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cyc_out_valid", fetch_bus.out_valid, m_q.size() != 0);
    if (rst_n) check("cyc_imem_pc", fetch_bus.imem_pc, m_pc);
    if (m_q.size() != 0) begin
      check("cyc_out_pc", fetch_bus.out_pc, m_q[0].pc);
      check("cyc_out_instr", fetch_bus.out_instr, m_q[0].instr);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("cyc_out_misalign", fetch_bus.out_misalign, m_q[0].mis);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    fetch_bus.redirect_valid = 1'b1;
    fetch_bus.redirect_pc    = pc;
    tick();
    fetch_bus.redirect_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
    check({name, "_valid"}, fetch_bus.out_valid, 1'b1);
    check({name, "_pc"}, fetch_bus.out_pc, pc);
    check({name, "_instr"}, fetch_bus.out_instr, instr);
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    fetch_bus.out_ready      = 1'b1;
    fetch_bus.redirect_valid = 1'b0;
    fetch_bus.redirect_pc    = 32'h0;
    #1;
    check("rst_out_valid", fetch_bus.out_valid, 1'b0);
    check("rst_out_pc", fetch_bus.out_pc, 32'h0);
    check("rst_out_instr", fetch_bus.out_instr, 32'h0);
    check("rst_imem_pc", fetch_bus.imem_pc, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_out_misalign", fetch_bus.out_misalign, 1'b0);
`endif

    // Streaming from reset, one entry per cycle.
    release_reset();
    check("t1_pre_valid", fetch_bus.out_valid, 1'b0);
    tick();
    expect_head("t1_a", 32'h0, 32'h0 ^ KEY);
    tick();
    expect_head("t1_b", 32'h4, 32'h4 ^ KEY);
    tick();
    expect_head("t1_c", 32'h8, 32'h8 ^ KEY);

    // Backpressure from reset: FIFO fills, fetch PC holds.
    rst_n = 1'b0;
    fetch_bus.out_ready = 1'b0;
    #1;
    check("t2_async_valid", fetch_bus.out_valid, 1'b0);
    release_reset();
    tick();
    expect_head("t2_a", 32'h0, 32'h0 ^ KEY);
    check("t2_imem_a", fetch_bus.imem_pc, 32'h4);
    tick();
    check("t2_imem_b", fetch_bus.imem_pc, 32'h8);
    tick();
    check("t2_imem_hold", fetch_bus.imem_pc, 32'h8);
    expect_head("t2_hold", 32'h0, 32'h0 ^ KEY);
    fetch_bus.out_ready = 1'b1;
    tick();
    expect_head("t2_b", 32'h4, 32'h4 ^ KEY);
    tick();
    expect_head("t2_c", 32'h8, 32'h8 ^ KEY);
    tick();
    expect_head("t2_d", 32'hC, 32'hC ^ KEY);

    // Redirect while full flushes the queued entries.
    fetch_bus.out_ready = 1'b0;
    tick();
    tick();
    redirect(32'h40);
    check("t3_flush_valid", fetch_bus.out_valid, 1'b0);
    tick();
    expect_head("t3_a", 32'h40, 32'h40 ^ KEY);
    tick();
    expect_head("t3_stall", 32'h40, 32'h40 ^ KEY);
    fetch_bus.out_ready = 1'b1;
    tick();
    expect_head("t3_b", 32'h44, 32'h44 ^ KEY);

    // Wrap at the top of memory; upper address bits discarded.
    redirect(32'h0000_1FF8);
    check("t4_flush_valid", fetch_bus.out_valid, 1'b0);
    tick();
    expect_head("t4_a", 32'hFF8, 32'hFF8 ^ KEY);
    tick();
    expect_head("t4_b", 32'hFFC, 32'hFFC ^ KEY);
    tick();
    expect_head("t4_c", 32'h000, 32'h000 ^ KEY);
    tick();
    expect_head("t4_d", 32'h004, 32'h004 ^ KEY);

    // Back-to-back redirects: the last one wins.
    fetch_bus.redirect_valid = 1'b1;
    fetch_bus.redirect_pc    = 32'h100;
    tick();
    redirect(32'h200);
    check("t5_b2b_valid", fetch_bus.out_valid, 1'b0);
    tick();
    expect_head("t5_b2b", 32'h200, 32'h200 ^ KEY);

    // Misaligned redirect target.
    redirect(32'h42);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    expect_head("t5_mis", 32'h42, 32'h0);
    check("t5_mis_flag", fetch_bus.out_misalign, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_halt_valid", fetch_bus.out_valid, 1'b0);
    end
    redirect(32'h80);
    tick();
    expect_head("t5_resume", 32'h80, 32'h80 ^ KEY);
    check("t5_resume_flag", fetch_bus.out_misalign, 1'b0);
`else
    expect_head("t5_align", 32'h40, 32'h40 ^ KEY);
    tick();
    expect_head("t5_align_next", 32'h44, 32'h44 ^ KEY);
`endif

    // Reset in the middle of a full FIFO.
    fetch_bus.out_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", fetch_bus.out_valid, 1'b0);
    check("t6_async_imem", fetch_bus.imem_pc, RESET_PC);
    check("t6_async_pc", fetch_bus.out_pc, 32'h0);
    tick();
    check("t6_hold_valid", fetch_bus.out_valid, 1'b0);
    release_reset();
    fetch_bus.out_ready = 1'b1;
    check("t6_rel_valid", fetch_bus.out_valid, 1'b0);
    tick();
    expect_head("t6_a", RESET_PC, RESET_PC ^ KEY);
    tick();
    expect_head("t6_b", RESET_PC + 32'h4, (RESET_PC + 32'h4) ^ KEY);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
